// File: rtl/segre_icache_refill_pkg.sv
// segre_icache_refill_pkg: shared refill FSM states and default bus geometry
package segre_icache_refill_pkg;
  localparam int ICACHE_LANE_SIZE = 128;
  localparam int MEM_DATA_SIZE = 32;
  localparam int ICACHE_BEATS = ICACHE_LANE_SIZE / MEM_DATA_SIZE;
  typedef enum logic [2:0] {
    RF_IDLE  = 3'd0,
    RF_REQ   = 3'd1,
    RF_FILL  = 3'd2,
    RF_DONE  = 3'd3,
    RF_DRAIN = 3'd4
  } refill_fsm_state_e;
endpackage

// File: rtl/segre_icache_refill_lru.sv
// segre_icache_lru: true-LRU age array; a hit touch applies first, a fill touch last
module segre_icache_lru #(
  parameter int ICACHE_INDEX_SIZE = 2
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         hit_i,
  input  logic [ICACHE_INDEX_SIZE-1:0] hit_idx_i,
  input  logic                         fill_i,
  input  logic [ICACHE_INDEX_SIZE-1:0] fill_idx_i,
  output logic [ICACHE_INDEX_SIZE-1:0] victim_o
);
  localparam int LINES = 1 << ICACHE_INDEX_SIZE;
  logic [ICACHE_INDEX_SIZE-1:0] age [LINES];
  logic [ICACHE_INDEX_SIZE-1:0] mid [LINES];
  logic [ICACHE_INDEX_SIZE-1:0] nxt [LINES];
  always_comb begin
    victim_o = '0;
    for (int i = 0; i < LINES; i++)
      mid[i] = !hit_i ? age[i] : ICACHE_INDEX_SIZE'(i) == hit_idx_i ? '0 :
               age[i] < age[hit_idx_i] ? age[i] + 1'b1 : age[i];
    for (int i = 0; i < LINES; i++)
      nxt[i] = !fill_i ? mid[i] : ICACHE_INDEX_SIZE'(i) == fill_idx_i ? '0 :
               mid[i] < mid[fill_idx_i] ? mid[i] + 1'b1 : mid[i];
    for (int i = 0; i < LINES; i++)
      if (age[i] == ICACHE_INDEX_SIZE'(LINES - 1)) victim_o = ICACHE_INDEX_SIZE'(i);
  end
  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) for (int i = 0; i < LINES; i++) age[i] <= ICACHE_INDEX_SIZE'(i);
    else age <= nxt;
endmodule

// File: rtl/segre_icache_refill.sv
// segre_icache_refill: I-cache miss refill engine, burst lane fetch and LRU victim write-back to fetch
module segre_icache_refill #(
  parameter int ADDR_SIZE = 32,
  parameter int ICACHE_LANE_SIZE = 128,
  parameter int ICACHE_INDEX_SIZE = 2,
  parameter int MEM_DATA_SIZE = segre_icache_refill_pkg::MEM_DATA_SIZE
) (
  input  logic                         clk_i,
  input  logic                         rsn_i,
  input  logic                         ic_access_i,
  input  logic                         ic_miss_i,
  input  logic [ADDR_SIZE-1:0]         ic_addr_i,
  input  logic                         abort_i,
  output logic                         mmu_data_o,
  output logic [ICACHE_LANE_SIZE-1:0]  mmu_wr_data_o,
  output logic [ICACHE_INDEX_SIZE-1:0] mmu_lru_index_o,
  output logic                         mem_req_o,
  output logic [ADDR_SIZE-1:0]         mem_addr_o,
  input  logic                         mem_gnt_i,
  input  logic                         mem_rvalid_i,
  input  logic [MEM_DATA_SIZE-1:0]     mem_rdata_i,
  output logic                         busy_o
);
  import segre_icache_refill_pkg::*;
  localparam int BEATS = ICACHE_LANE_SIZE / MEM_DATA_SIZE;
  localparam int BEAT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int LANE_OFF = $clog2(ICACHE_LANE_SIZE / 8);
  refill_fsm_state_e state, state_n;
  logic [BEAT_W-1:0] beat;
  logic [ICACHE_INDEX_SIZE-1:0] victim;
  logic accept, last, take, unused_addr;
  assign accept = state == RF_IDLE && ic_access_i && ic_miss_i;
  assign last = beat == BEAT_W'(BEATS - 1);
  assign take = (state == RF_FILL || state == RF_DRAIN) && mem_rvalid_i;
  assign unused_addr = ^ic_addr_i;
  // a final beat wins over a simultaneous abort: the lane is already complete
  always_comb
    state_n = state == RF_IDLE  ? (accept ? RF_REQ : RF_IDLE) :
              state == RF_REQ   ? (abort_i ? (mem_gnt_i ? RF_DRAIN : RF_IDLE) : mem_gnt_i ? RF_FILL : RF_REQ) :
              state == RF_FILL  ? (take && last ? RF_DONE : abort_i ? RF_DRAIN : RF_FILL) :
              state == RF_DRAIN ? (take && last ? RF_IDLE : RF_DRAIN) : RF_IDLE;
  always_ff @(posedge clk_i or negedge rsn_i)
    if (!rsn_i) begin
      state           <= RF_IDLE;
      beat            <= '0;
      mem_addr_o      <= '0;
      mmu_lru_index_o <= '0;
      mmu_wr_data_o   <= '0;
    end else begin
      state <= state_n;
      beat  <= accept || (take && last) ? '0 : take ? beat + 1'b1 : beat;
      if (accept) begin
        mem_addr_o      <= {ic_addr_i[ADDR_SIZE-1:LANE_OFF], {LANE_OFF{1'b0}}};
        mmu_lru_index_o <= victim;
      end
      if (take && state == RF_FILL) mmu_wr_data_o[MEM_DATA_SIZE*beat +: MEM_DATA_SIZE] <= mem_rdata_i;
    end
  assign mmu_data_o = state == RF_DONE;
  assign mem_req_o  = state == RF_REQ;
  assign busy_o     = state != RF_IDLE;
  segre_icache_lru #(.ICACHE_INDEX_SIZE(ICACHE_INDEX_SIZE)) u_lru (
    .clk_i      (clk_i),
    .rsn_i      (rsn_i),
    .hit_i      (ic_access_i && !ic_miss_i),
    .hit_idx_i  (ic_addr_i[ICACHE_INDEX_SIZE-1:0]),
    .fill_i     (mmu_data_o),
    .fill_idx_i (mmu_lru_index_o),
    .victim_o   (victim)
  );
endmodule

// File: tb/tb_segre_icache_refill.sv
// tb_segre_icache_refill: directed and random refills checked against a recency-list LRU model
module tb_segre_icache_refill;
  import segre_icache_refill_pkg::*;
  localparam int AW = 32, LW = 128, IW = 2, DW = 32, NB = ICACHE_BEATS;
  logic clk_i = 0, rsn_i = 0, ic_access_i = 0, ic_miss_i = 0, abort_i = 0;
  logic mem_gnt_i = 0, mem_rvalid_i = 0;
  logic [AW-1:0] ic_addr_i = '0;
  logic [DW-1:0] mem_rdata_i = '0;
  logic mmu_data_o, mem_req_o, busy_o;
  logic [LW-1:0] mmu_wr_data_o;
  logic [IW-1:0] mmu_lru_index_o;
  logic [AW-1:0] mem_addr_o;
  int vectors = 0, errors = 0;
  int q[$];
  always #5 clk_i = ~clk_i;
  segre_icache_refill dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .ic_access_i(ic_access_i), .ic_miss_i(ic_miss_i),
    .ic_addr_i(ic_addr_i), .abort_i(abort_i), .mmu_data_o(mmu_data_o),
    .mmu_wr_data_o(mmu_wr_data_o), .mmu_lru_index_o(mmu_lru_index_o), .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );
  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  // most recently used at the front, victim at the back
  task automatic touch(input int t);
    for (int i = 0; i < q.size(); i++) if (q[i] == t) begin q.delete(i); break; end
    q.push_front(t);
  endtask
  task automatic tick(input bit rnd);
    int h = -1;
    if (rnd && $urandom_range(0, 2) == 0) begin
      h = $urandom_range(0, 3);
      ic_access_i = 1; ic_miss_i = 0; ic_addr_i = ($urandom() & ~32'h3) | h;
    end
    step();
    ic_access_i = 0;
    if (h >= 0) touch(h);
  endtask
  task automatic hit(input int idx);
    ic_access_i = 1; ic_miss_i = 0; ic_addr_i = 32'h0000_8000 | idx;
    step();
    ic_access_i = 0;
    touch(idx);
  endtask
  task automatic start_miss(input logic [AW-1:0] addr);
    ic_access_i = 1; ic_miss_i = 1; ic_addr_i = addr;
    step();
    ic_access_i = 0; ic_miss_i = 0;
  endtask
  task automatic beat();
    mem_rvalid_i = 1; mem_rdata_i = $urandom();
    step();
    mem_rvalid_i = 0;
  endtask
  task automatic refill(input logic [AW-1:0] addr, input int gdly, input int gap, input bit rnd,
                        input logic [LW-1:0] dat);
    int v, cyc, h;
    bit m;
    logic [AW-1:0] la;
    la = addr & ~32'hF;
    v = q[$];
    start_miss(addr);
    cyc = 1;
    chk("req", mem_req_o, 1);
    chk("addr", mem_addr_o, la);
    repeat (gdly) begin
      tick(rnd); cyc++;
      chk("req_hold", mem_req_o, 1);
      chk("addr_hold", mem_addr_o, la);
    end
    mem_gnt_i = 1; tick(rnd); mem_gnt_i = 0; cyc++;
    chk("req_drop", mem_req_o, 0);
    for (int k = 0; k < NB; k++) begin
      repeat (gap > 0 ? $urandom_range(0, gap) : 0) begin
        tick(rnd); cyc++;
        chk("gap_no_strobe", mmu_data_o, 0);
      end
      mem_rvalid_i = 1; mem_rdata_i = dat[DW*k +: DW];
      tick(rnd); mem_rvalid_i = 0; cyc++;
      if (k < NB - 1) chk("early_strobe", mmu_data_o, 0);
    end
    chk("strobe", mmu_data_o, 1);
    chk("lane", mmu_wr_data_o, dat);
    chk("victim", mmu_lru_index_o, v);
    if (gdly == 0 && gap == 0) chk("latency", cyc, 2 + NB);
    m = 0; h = -1;
    if (rnd) begin
      m = 1'($urandom_range(0, 1)); h = $urandom_range(0, 3);
      ic_access_i = 1; ic_miss_i = m; ic_addr_i = ($urandom() & ~32'h3) | h;
      abort_i = 1;
    end
    step();
    ic_access_i = 0; ic_miss_i = 0; abort_i = 0;
    if (rnd && !m) touch(h);
    touch(v);
    chk("one_pulse", mmu_data_o, 0);
    chk("idle_after", busy_o, 0);
    chk("lane_hold", mmu_wr_data_o, dat);
  endtask
  function automatic logic [LW-1:0] rnd_lane();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  initial begin
    q = '{0, 1, 2, 3};
    repeat (2) step();
    chk("rst_strobe", mmu_data_o, 0);
    chk("rst_lane", mmu_wr_data_o, 0);
    chk("rst_idx", mmu_lru_index_o, 0);
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_busy", busy_o, 0);
    rsn_i = 1;
    step();
    refill(32'h0000_1004, 0, 0, 0, 128'h44444444_33333333_22222222_11111111);
    refill(32'h0000_2A3C, 5, 3, 0, rnd_lane());
    hit(0); hit(1); hit(2);
    refill(32'h0000_3008, 0, 0, 0, rnd_lane());
    refill(32'h0000_4010, 1, 1, 0, rnd_lane());
    hit(3);
    refill(32'h0000_5000, 0, 0, 0, rnd_lane());
    // abort after two beats, then drain the other two
    start_miss(32'h0000_6000);
    mem_gnt_i = 1; step(); mem_gnt_i = 0;
    beat(); beat();
    abort_i = 1; step(); abort_i = 0;
    chk("abort_fill_busy", busy_o, 1);
    chk("abort_fill_strobe", mmu_data_o, 0);
    beat();
    chk("drain_busy", busy_o, 1);
    beat();
    chk("drain_done_busy", busy_o, 0);
    chk("drain_no_strobe", mmu_data_o, 0);
    refill(32'h0000_6000, 0, 0, 0, rnd_lane());
    // abort before grant, then a stray beat
    start_miss(32'h0000_7000);
    chk("abort_req_pre", mem_req_o, 1);
    abort_i = 1; step(); abort_i = 0;
    chk("abort_req_drop", mem_req_o, 0);
    chk("abort_req_busy", busy_o, 0);
    beat();
    chk("stray_busy", busy_o, 0);
    chk("stray_strobe", mmu_data_o, 0);
    refill(32'h0000_7000, 2, 0, 0, rnd_lane());
    // abort together with grant drains a full burst
    start_miss(32'h0000_8000);
    abort_i = 1; mem_gnt_i = 1; step(); abort_i = 0; mem_gnt_i = 0;
    chk("abort_gnt_busy", busy_o, 1);
    repeat (NB - 1) beat();
    chk("abort_gnt_drain", busy_o, 1);
    beat();
    chk("abort_gnt_idle", busy_o, 0);
    chk("abort_gnt_strobe", mmu_data_o, 0);
    for (int n = 0; n < 30; n++)
      refill($urandom(), $urandom_range(0, 4), $urandom_range(0, 2), 1, rnd_lane());
    // asynchronous reset in the middle of a fill
    hit(3); hit(1);
    start_miss(32'h0000_9000);
    mem_gnt_i = 1; step(); mem_gnt_i = 0;
    beat();
    #2 rsn_i = 0;
    #1;
    chk("arst_strobe", mmu_data_o, 0);
    chk("arst_lane", mmu_wr_data_o, 0);
    chk("arst_idx", mmu_lru_index_o, 0);
    chk("arst_req", mem_req_o, 0);
    chk("arst_addr", mem_addr_o, 0);
    chk("arst_busy", busy_o, 0);
    q = '{0, 1, 2, 3};
    #3 rsn_i = 1;
    step();
    beat(); beat();
    chk("post_rst_stray", busy_o, 0);
    refill(32'h0000_A00C, 0, 0, 0, rnd_lane());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/segre_icache_refill.md
# segre_icache_refill

Instruction-cache refill engine sitting directly upstream of the fetch stage. It accepts an I-cache miss from fetch, selects a victim line by true LRU, fetches the missing lane from memory as a burst of bus-width beats, and returns the assembled lane to the fetch stage's tag and data arrays with a one-cycle write strobe. It also tracks LRU ages from fetch hits and supports aborting an in-flight refill on pipeline recovery.

## Interface
Parameters:
- ADDR_SIZE, 32, address width
- ICACHE_LANE_SIZE, 128, lane width in bits
- ICACHE_INDEX_SIZE, 2, line index width (4 lines)
- MEM_DATA_SIZE, 32, memory beat width; ICACHE_LANE_SIZE must be a multiple of it

Ports:
- clk_i  in  1  clock
- rsn_i  in  1  reset; asynchronous, active-low
- ic_access_i  in  1  fetch performed a lookup this cycle
- ic_miss_i  in  1  lookup missed
- ic_addr_i  in  ADDR_SIZE  miss address on a miss; hit line index in the low ICACHE_INDEX_SIZE bits on a hit
- abort_i  in  1  drop the current refill (pipeline recovery)
- mmu_data_o  out  1  one-cycle lane write strobe to fetch
- mmu_wr_data_o  out  ICACHE_LANE_SIZE  assembled lane
- mmu_lru_index_o  out  ICACHE_INDEX_SIZE  victim line index
- mem_req_o  out  1  memory read request
- mem_addr_o  out  ADDR_SIZE  lane-aligned request address
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read beat valid
- mem_rdata_i  in  MEM_DATA_SIZE  read beat
- busy_o  out  1  state is not RF_IDLE

## Operation
- BEATS = ICACHE_LANE_SIZE/MEM_DATA_SIZE; LANE_OFF = log2(ICACHE_LANE_SIZE/8).
- RF_IDLE: if ic_access_i & ic_miss_i, latch line address {ic_addr_i[ADDR_SIZE-1:LANE_OFF], LANE_OFF'b0}, latch the LRU victim, clear the beat counter, then go to RF_REQ.
- RF_REQ: mem_req_o=1 and mem_addr_o stable until mem_gnt_i, then go to RF_FILL.
  - abort_i without mem_gnt_i: go to RF_IDLE.
  - abort_i together with mem_gnt_i: go to RF_DRAIN.
- RF_FILL: each mem_rvalid_i writes beat k to bits [MEM_DATA_SIZE*k +: MEM_DATA_SIZE], and k increments.
  - On beat BEATS-1, go to RF_DONE.
  - abort_i: go to RF_DRAIN. A beat arriving in the same cycle is still counted.
- RF_DRAIN: count the remaining beats and discard them. After the last beat go to RF_IDLE with no strobe.
- RF_DONE: mmu_data_o=1 for exactly this cycle, and the victim's LRU age is touched. Go to RF_IDLE unconditionally.
  - ic_miss_i is ignored in this state.
  - abort_i does not suppress the strobe, because the lane is valid.
- mem_rvalid_i outside RF_FILL/RF_DRAIN and mem_gnt_i outside RF_REQ are ignored.
- LRU uses 2-bit ages per line (4 lines).
  - Victim = the line with age 3.
  - Touching line t sets age[t]=0 and increments every line whose age is below the old age[t].
  - Touch sources: a hit (ic_access_i & !ic_miss_i, index ic_addr_i[ICACHE_INDEX_SIZE-1:0]) and the RF_DONE fill.
  - If both occur in the same cycle, apply the fill touch last.
  - Ages always remain a permutation of 0..3.

## Timing
- Reset values: all outputs 0, fill buffer 0, state RF_IDLE, age[i]=i (so the first victim is line 3).
- Reset mid-operation returns to RF_IDLE immediately; outstanding memory beats after reset are ignored.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Miss sampled at edge N:
  - mem_req_o is high from cycle N+1.
  - With grant at N+1 and one beat per cycle from N+2, mmu_data_o is high in cycle N+2+BEATS (N+6 for the defaults).
- mmu_wr_data_o and mmu_lru_index_o are valid only while mmu_data_o=1. They hold their values until the next refill.
- The earliest a new miss can be accepted is the cycle after RF_DONE.

## Structure
- Shared package additions:
  - refill_fsm_state_e {RF_IDLE, RF_REQ, RF_FILL, RF_DONE, RF_DRAIN}
  - ICACHE_BEATS constant
  - MEM_DATA_SIZE constant
- Sub-module segre_icache_lru: age array, touch port, victim output; parameterised by ICACHE_INDEX_SIZE.
- Top module contains the FSM, beat counter, address latch and fill buffer.

## Test plan
- Reset, then miss at 0x0000_1004, grant immediate, beats 0x11111111..0x44444444 → mem_addr_o=0x0000_1000; in cycle N+6 mmu_data_o=1, mmu_wr_data_o=0x44444444_33333333_22222222_11111111, mmu_lru_index_o=3.
- Grant delayed 5 cycles and beats spaced by idle cycles → mem_req_o and mem_addr_o stable while waiting; exactly one mmu_data_o pulse after the 4th beat.
- Hits on lines 0,1,2 then miss → victim is 3. A second refill then hits line 3 → next miss victim is 0.
- abort_i after 2 of 4 beats → no strobe; state returns to RF_IDLE after 2 more beats; a subsequent miss fills cleanly.
- abort_i in RF_REQ before grant → mem_req_o drops next cycle; no strobe; stray mem_rvalid_i is ignored.
- rsn_i asserted asynchronously during RF_FILL → all outputs 0 immediately; ages reset to 0,1,2,3.
